// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM state encoding,
// default port widths and the fetch-starvation threshold.
package mem_arbiter_pkg;

    localparam int unsigned DEF_ADDR_W   = 32;
    localparam int unsigned DEF_DATA_W   = 32;
    localparam int unsigned DEF_MAX_WAIT = 4;

    // Width of the fetch age counter; MAX_WAIT must fit in it (1..15).
    localparam int unsigned AGE_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        LS_BUSY = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_arbiter_age_counter.sv
// Saturating fetch age counter: counts the idle cycles a fetch request has
// been passed over, so the arbiter can force a fetch grant after MAX_WAIT.
module arb_age_counter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [AGE_W-1:0] count
);

    localparam logic [AGE_W-1:0] AGE_LIMIT = AGE_W'(MAX_WAIT);

    logic [AGE_W-1:0] r_count;

    // Clear wins over increment; increment stops at the starvation limit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count < AGE_LIMIT)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between an instruction-fetch port
// and a load-store port. One transaction outstanding at a time; load-store
// has priority unless the fetch has been starved for MAX_WAIT idle cycles.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic                clk,
    input  logic                reset,
    // instruction fetch port
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    // load-store port
    input  logic                ls_req,
    input  logic                ls_we,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic [DATA_W-1:0]   ls_wdata,
    input  logic [DATA_W/8-1:0] ls_be,
    output logic                ls_gnt,
    output logic                ls_rvalid,
    output logic [DATA_W-1:0]   ls_rdata,
    // shared memory port
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_ready,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int unsigned      BE_W      = DATA_W / 8;
    localparam logic [AGE_W-1:0] AGE_LIMIT = AGE_W'(MAX_WAIT);

    arb_state_e       r_state;
    arb_state_e       w_state_next;
    logic [AGE_W-1:0] w_age;
    logic             w_if_wins;
    logic             w_ls_wins;
    logic             w_if_gnt;
    logic             w_ls_gnt;
    logic             w_busy;
    logic             w_done;
    logic             w_age_inc;

    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [DATA_W-1:0] r_wdata;
    logic [BE_W-1:0]   r_be;
    logic              r_if_rvalid;
    logic              r_ls_rvalid;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_ls_rdata;

    assign w_busy = (r_state != IDLE);
    assign w_done = w_busy && mem_ready;

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Arbitration, grants and next state; grants exist only while idle
    always_comb begin
        w_state_next = r_state;
        w_if_gnt     = 1'b0;
        w_ls_gnt     = 1'b0;
        w_if_wins    = if_req && (!ls_req || (w_age >= AGE_LIMIT));
        w_ls_wins    = ls_req && !w_if_wins;
        case (r_state)
            IDLE: begin
                w_if_gnt = w_if_wins;
                w_ls_gnt = w_ls_wins;
                if (w_if_wins) begin
                    w_state_next = IF_BUSY;
                end else if (w_ls_wins) begin
                    w_state_next = LS_BUSY;
                end
            end
            IF_BUSY, LS_BUSY: begin
                if (mem_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Grants are forced low while reset is held so every output reads 0.
    assign if_gnt = w_if_gnt & reset;
    assign ls_gnt = w_ls_gnt & reset;

    // Fetch loses an idle cycle whenever it asks and is not granted.
    assign w_age_inc = (r_state == IDLE) && if_req && !w_if_gnt;

    arb_age_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_age (
        .clk   (clk),
        .reset (reset),
        .inc   (w_age_inc),
        .clr   (w_if_gnt),
        .count (w_age)
    );

    // Capture the winner's request fields on the grant edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_be    <= '0;
        end else if (w_if_gnt) begin
            r_addr  <= if_addr;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_be    <= '1;
        end else if (w_ls_gnt) begin
            r_addr  <= ls_addr;
            r_we    <= ls_we;
            r_wdata <= ls_wdata;
            r_be    <= ls_be;
        end
    end

    // Completion pulses and read data, routed to whichever port owned the memory
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_if_rvalid <= 1'b0;
            r_ls_rvalid <= 1'b0;
            r_if_rdata  <= '0;
            r_ls_rdata  <= '0;
        end else begin
            r_if_rvalid <= w_done && (r_state == IF_BUSY);
            r_ls_rvalid <= w_done && (r_state == LS_BUSY);
            if (w_done && (r_state == IF_BUSY)) begin
                r_if_rdata <= mem_rdata;
            end
            if (w_done && (r_state == LS_BUSY)) begin
                r_ls_rdata <= mem_rdata;
            end
        end
    end

    // Memory request follows the busy state, so it drops as soon as reset hits;
    // the request fields are zeroed whenever no request is presented.
    assign mem_req   = w_busy;
    assign mem_we    = w_busy ? r_we    : 1'b0;
    assign mem_addr  = w_busy ? r_addr  : '0;
    assign mem_wdata = w_busy ? r_wdata : '0;
    assign mem_be    = w_busy ? r_be    : '0;

    assign if_rvalid = r_if_rvalid;
    assign if_rdata  = r_if_rdata;
    assign ls_rvalid = r_ls_rvalid;
    assign ls_rdata  = r_ls_rdata;

endmodule
